slow_word_logger: RTL and testbench



---
 rtl/slow_word_logger.sv | 175 +++++++++++++++++
 tb/tb_slow_word_logger.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/slow_word_logger.sv
// Purpose : debug tap that serialises each accepted slow word as 8N1 UART bytes (sync byte, then MSB byte first).
// Latency : start bit leaves o_uart_tx on the cycle after acceptance; frame is (1+DATA_BYTES)*10*CPB cycles, then DEAD_CLKS idle.
// Backpressure: never stalls the host; strobes while busy are dropped and counted (saturating).
// Ports   : i_clk/i_reset (sync, active-high); i_data_valid/i_data slow-word strobe;
//           o_ready high in IDLE only; o_drop_count saturating reject count; o_uart_tx serial out, idle high.
// CPB = CLK_RATE_HZ / BAUD_RATE must be at least 2.
module slow_word_logger #(
  parameter int         DATA_BYTES  = 6,
  parameter int         CLK_RATE_HZ = 60_000_000,
  parameter int         BAUD_RATE   = 115_200,
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         DEAD_CLKS   = 6000
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_data_valid,
  input  logic [8*DATA_BYTES-1:0] i_data,
  output logic                    o_ready,
  output logic [7:0]              o_drop_count,
  output logic                    o_uart_tx
);

  localparam int CPB    = CLK_RATE_HZ / BAUD_RATE;
  localparam int WORD_W = 8 * DATA_BYTES;
  localparam int CPB_W  = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int DEAD_W = (DEAD_CLKS > 0) ? $clog2(DEAD_CLKS + 1) : 1;
  localparam int IDX_W  = $clog2(DATA_BYTES + 1);

  localparam logic [CPB_W-1:0]  CPB_LAST  = CPB_W'(CPB - 1);
  localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'((DEAD_CLKS > 0) ? DEAD_CLKS - 1 : 0);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DATA_BYTES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_DEAD
  } state_t;

  state_t              state, state_n;
  logic [WORD_W-1:0]   shift_reg, shift_reg_n;  // remaining payload, next byte at the top
  logic [7:0]          cur_byte, cur_byte_n;    // byte on the wire, LSB is the current bit
  logic [IDX_W-1:0]    byte_idx, byte_idx_n;    // 0 = sync byte, 1..DATA_BYTES = payload
  logic [2:0]          bit_idx, bit_idx_n;
  logic [CPB_W-1:0]    baud_cnt, baud_cnt_n;
  logic [DEAD_W-1:0]   dead_cnt, dead_cnt_n;
  logic                tx_r, tx_n;
  logic [7:0]          drop_cnt, drop_cnt_n;

  assign o_ready      = (state == S_IDLE);
  assign o_uart_tx    = tx_r;
  assign o_drop_count = drop_cnt;

  always_comb begin
    state_n     = state;
    shift_reg_n = shift_reg;
    cur_byte_n  = cur_byte;
    byte_idx_n  = byte_idx;
    bit_idx_n   = bit_idx;
    baud_cnt_n  = baud_cnt;
    dead_cnt_n  = dead_cnt;
    tx_n        = tx_r;
    drop_cnt_n  = drop_cnt;

    if (i_data_valid && (state != S_IDLE) && (drop_cnt != 8'hFF)) begin
      drop_cnt_n = drop_cnt + 8'd1;
    end

    // tx_n is the line level for the state being entered, so the pin is
    // a plain register and changes on the same edge as the state.
    case (state)
      S_IDLE: begin
        tx_n = 1'b1;
        if (i_data_valid) begin
          shift_reg_n = i_data;
          cur_byte_n  = SYNC_BYTE;
          byte_idx_n  = '0;
          baud_cnt_n  = '0;
          tx_n        = 1'b0;
          state_n     = S_START;
        end
      end

      S_START: begin
        if (baud_cnt == CPB_LAST) begin
          baud_cnt_n = '0;
          bit_idx_n  = 3'd0;
          tx_n       = cur_byte[0];
          state_n    = S_DATA;
        end else begin
          baud_cnt_n = baud_cnt + 1'b1;
        end
      end

      S_DATA: begin
        if (baud_cnt == CPB_LAST) begin
          baud_cnt_n = '0;
          if (bit_idx == 3'd7) begin
            tx_n    = 1'b1;
            state_n = S_STOP;
          end else begin
            bit_idx_n  = bit_idx + 3'd1;
            cur_byte_n = {1'b0, cur_byte[7:1]};
            tx_n       = cur_byte[1];
          end
        end else begin
          baud_cnt_n = baud_cnt + 1'b1;
        end
      end

      S_STOP: begin
        if (baud_cnt == CPB_LAST) begin
          baud_cnt_n = '0;
          if (byte_idx < LAST_IDX) begin
            byte_idx_n  = byte_idx + 1'b1;
            cur_byte_n  = shift_reg[WORD_W-1 -: 8];
            shift_reg_n = shift_reg << 8;
            tx_n        = 1'b0;
            state_n     = S_START;
          end else if (DEAD_CLKS == 0) begin
            tx_n    = 1'b1;
            state_n = S_IDLE;
          end else begin
            dead_cnt_n = '0;
            tx_n       = 1'b1;
            state_n    = S_DEAD;
          end
        end else begin
          baud_cnt_n = baud_cnt + 1'b1;
        end
      end

      S_DEAD: begin
        tx_n = 1'b1;
        if (dead_cnt == DEAD_LAST) begin
          dead_cnt_n = '0;
          state_n    = S_IDLE;
        end else begin
          dead_cnt_n = dead_cnt + 1'b1;
        end
      end

      default: begin
        tx_n    = 1'b1;
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= S_IDLE;
      shift_reg <= '0;
      cur_byte  <= '0;
      byte_idx  <= '0;
      bit_idx   <= '0;
      baud_cnt  <= '0;
      dead_cnt  <= '0;
      tx_r      <= 1'b1;
      drop_cnt  <= '0;
    end else begin
      state     <= state_n;
      shift_reg <= shift_reg_n;
      cur_byte  <= cur_byte_n;
      byte_idx  <= byte_idx_n;
      bit_idx   <= bit_idx_n;
      baud_cnt  <= baud_cnt_n;
      dead_cnt  <= dead_cnt_n;
      tx_r      <= tx_n;
      drop_cnt  <= drop_cnt_n;
    end
  end

endmodule

// File: tb/tb_slow_word_logger.sv
// Purpose : exercises slow_word_logger with directed words; a UART decoder on the main instance pops expected bytes.
// Latency : checks start-bit, frame-length, ready-rise and dead-gap timing in clock cycles.
// Backpressure: mid-frame strobes must be dropped/counted and never reach the serial stream.
module tb_slow_word_logger;

  localparam int CPB = 10;

  logic        clk;
  logic        rst;
  logic        valid0, valid1;
  logic [47:0] data0, data1;
  logic        ready0, ready1;
  logic [7:0]  drop0, drop1;
  logic        tx0, tx1;

  int total;
  int bad;
  int cyc;

  logic [7:0] exp_q[$];

  slow_word_logger #(
    .DATA_BYTES(6), .CLK_RATE_HZ(1_000_000), .BAUD_RATE(100_000),
    .SYNC_BYTE(8'hA5), .DEAD_CLKS(20)
  ) u_dut (
    .i_clk(clk), .i_reset(rst), .i_data_valid(valid0), .i_data(data0),
    .o_ready(ready0), .o_drop_count(drop0), .o_uart_tx(tx0)
  );

  slow_word_logger #(
    .DATA_BYTES(6), .CLK_RATE_HZ(1_000_000), .BAUD_RATE(100_000),
    .SYNC_BYTE(8'hA5), .DEAD_CLKS(0)
  ) u_dut_nodead (
    .i_clk(clk), .i_reset(rst), .i_data_valid(valid1), .i_data(data1),
    .o_ready(ready1), .o_drop_count(drop1), .o_uart_tx(tx1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [47:0] w);
    exp_q.push_back(8'hA5);
    for (int i = 5; i >= 0; i--) exp_q.push_back(w[8*i +: 8]);
  endtask

  // Returns with cyc equal to the acceptance edge.
  task automatic strobe0(input logic [47:0] w);
    valid0 = 1'b1;
    data0  = w;
    tick();
    valid0 = 1'b0;
  endtask

  task automatic wait_ready0(input int bound);
    int n;
    n = 0;
    while (ready0 !== 1'b1 && n < bound) begin
      tick();
      n++;
    end
    chk("ready_timeout", ready0, 1);
  endtask

  // UART decoder on the main instance: one sample per cycle, every bit
  // must hold for exactly CPB samples.
  int         rx_active;
  int         rx_bit;
  int         rx_cnt;
  logic       rx_cur;
  logic       rx_err;
  logic [9:0] rx_fr;
  int         rx_last_stop_cyc;

  always @(negedge clk) begin
    if (rst) begin
      rx_active = 0;
    end else if (rx_active == 0) begin
      if (tx0 === 1'b0) begin
        rx_active = 1;
        rx_bit    = 0;
        rx_cnt    = 1;
        rx_cur    = 1'b0;
        rx_err    = 1'b0;
      end
    end else begin
      if (rx_cnt == 0) rx_cur = tx0;
      else if (tx0 !== rx_cur) rx_err = 1'b1;
      rx_cnt++;
      if (rx_cnt == CPB) begin
        rx_fr[rx_bit] = rx_cur;
        rx_cnt = 0;
        rx_bit++;
        if (rx_bit == 10) begin
          rx_active        = 0;
          rx_last_stop_cyc = cyc;
          chk("bit_width", rx_err, 0);
          chk("start_stop", {rx_fr[9], rx_fr[0]}, 2'b10);
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_byte act=%0h exp=none", rx_fr[8:1]);
          end else begin
            chk("byte", rx_fr[8:1], exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog act=running exp=finished");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_a [7];
    int n_acc;
    int n;

    exp_a = '{8'hA5, 8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB};
    total = 0;
    bad   = 0;
    rst    = 1'b1;
    valid0 = 1'b0;
    valid1 = 1'b0;
    data0  = '0;
    data1  = '0;

    // Reset state
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_tx", tx0, 1);
    chk("rst_ready", ready0, 1);
    chk("rst_drop", drop0, 0);

    // Single word, hand-computed byte sequence
    for (int i = 0; i < 7; i++) exp_q.push_back(exp_a[i]);
    strobe0(48'h0123_4567_89AB);
    n_acc = cyc;
    chk("start_bit", tx0, 0);
    chk("busy_ready", ready0, 0);
    wait_ready0(2000);
    chk("frame_len", rx_last_stop_cyc - n_acc + 1, 700);
    // Sample after edge N+k is cycle N+k+1 in the acceptance-relative
    // numbering, so a 721-cycle ready rise is observed 720 edges later.
    chk("ready_rise", cyc - n_acc, 720);

    // Drops: three mid-frame strobes carrying other data
    push_word(48'hDEAD_BEEF_0042);
    strobe0(48'hDEAD_BEEF_0042);
    repeat (5) tick();
    strobe0(48'h1111_1111_1111);
    repeat (100) tick();
    strobe0(48'h2222_2222_2222);
    repeat (300) tick();
    strobe0(48'h3333_3333_3333);
    wait_ready0(2000);
    chk("drop_3", drop0, 3);

    // Boundary: strobe on the last DEAD cycle, then one cycle later
    push_word(48'hFEDC_BA98_7654);
    strobe0(48'hFEDC_BA98_7654);
    n_acc = cyc;
    while (cyc < n_acc + 719) tick();
    chk("last_dead_ready", ready0, 0);
    valid0 = 1'b1;
    data0  = 48'h5555_5555_5555;
    tick();
    chk("last_dead_drop", drop0, 4);
    chk("first_idle_ready", ready0, 1);
    push_word(48'hC0FF_EE00_1234);
    data0 = 48'hC0FF_EE00_1234;
    tick();
    valid0 = 1'b0;
    chk("first_idle_start", tx0, 0);
    chk("first_idle_busy", ready0, 0);
    wait_ready0(2000);

    // Saturation: 300 strobes during one frame
    push_word(48'h00FF_00FF_A55A);
    strobe0(48'h00FF_00FF_A55A);
    for (int i = 0; i < 300; i++) begin
      valid0 = 1'b1;
      data0  = 48'hFFFF_0000_0000 ^ 48'(i);
      tick();
      if (i == 99) chk("drop_104", drop0, 104);
    end
    valid0 = 1'b0;
    wait_ready0(2000);
    chk("drop_sat", drop0, 255);

    // Reset during the third byte (byte index 2)
    push_word(48'h1357_9BDF_2468);
    strobe0(48'h1357_9BDF_2468);
    n_acc = cyc;
    while (cyc < n_acc + 250) tick();
    rst = 1'b1;
    exp_q.delete();
    tick();
    chk("midrst_tx", tx0, 1);
    chk("midrst_ready", ready0, 1);
    chk("midrst_drop", drop0, 0);
    rst = 1'b0;
    tick();
    push_word(48'hA1B2_C3D4_E5F6);
    strobe0(48'hA1B2_C3D4_E5F6);
    wait_ready0(2000);
    chk("queue_empty", exp_q.size(), 0);

    // DEAD_CLKS = 0: strobe on the first IDLE cycle after the frame
    valid1 = 1'b1;
    data1  = 48'h0123_4567_89AB;
    tick();
    valid1 = 1'b0;
    n_acc = cyc;
    n = 0;
    while (ready1 !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    chk("nd_ready_timeout", ready1, 1);
    chk("nd_ready_rise", cyc - n_acc, 700);
    chk("nd_gap_high", tx1, 1);
    valid1 = 1'b1;
    data1  = 48'hFEDC_BA98_7654;
    tick();
    valid1 = 1'b0;
    chk("nd_second_start", tx1, 0);
    chk("nd_second_busy", ready1, 0);
    chk("nd_drop", drop1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
